// File: rtl/m_seq_pkg.sv
// Shared M-sequence definitions: default polynomial b[n] = b[n-4] ^ b[n-1]
// and the checker state encoding, used by both generator and checker ends.
package m_seq_pkg;

  localparam int MSEQ_WIDTH = 4;
  localparam int MSEQ_TAP   = 3;
  localparam int MSEQ_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } seq_state_e;

endpackage

// File: rtl/m_seq_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module m_seq_sat_counter #(
  parameter int W = 16
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // sys_rst_n is an active-high synchronous reset despite its name
  always_ff @(posedge sys_clk) begin
    if (sys_rst_n) count_q <= '0;
    else           count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/m_sequence_checker.sv
// Self-synchronising M-sequence BER checker with flywheel prediction once locked.
// Optional bit_count output (for BER) is enabled by defining MSEQ_CHK_STATS_EN.
//   state  | meaning
//   HUNT   | filling history from the received stream
//   VERIFY | counting consecutive correct predictions toward lock
//   LOCKED | flywheel: predicting locally, flagging and counting mismatches
module m_sequence_checker
  import m_seq_pkg::*;
#(
  parameter int WIDTH       = MSEQ_WIDTH,
  parameter int TAP         = MSEQ_TAP,
  parameter int LOCK_CNT    = 8,
  parameter int UNLOCK_ERRS = 4,
  parameter int CNT_W       = MSEQ_CNT_W
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       state_o
`ifdef MSEQ_CHK_STATS_EN
  ,
  output logic [CNT_W-1:0] bit_count
`endif
);

  localparam int FILL_W = $clog2(WIDTH + 1);
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(UNLOCK_ERRS + 1);

  localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(WIDTH);
  localparam logic [GOOD_W-1:0] GOOD_DONE = GOOD_W'(LOCK_CNT);
  localparam logic [BAD_W-1:0]  BAD_DONE  = BAD_W'(UNLOCK_ERRS);

  seq_state_e        state_q, state_d;
  logic [WIDTH-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [BAD_W-1:0]  bad_q, bad_d;
  logic              err_q, err_d;
  logic              pred;
  logic              err_inc;
  logic              bit_inc;

  assign pred = hist_q[WIDTH-1] ^ hist_q[WIDTH-1-TAP];

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    good_d  = good_q;
    bad_d   = bad_q;
    err_d   = 1'b0;
    err_inc = 1'b0;
    bit_inc = 1'b0;
    if (in_valid) begin
      case (state_q)
        ST_HUNT: begin
          hist_d = {hist_q[WIDTH-2:0], in_bit};
          fill_d = fill_q + FILL_W'(1);
          if (fill_d == FILL_DONE) begin
            state_d = ST_VERIFY;
            good_d  = '0;
          end
        end
        ST_VERIFY: begin
          hist_d = {hist_q[WIDTH-2:0], in_bit};
          if (in_bit == pred) good_d = good_q + GOOD_W'(1);
          else                good_d = '0;
          // an all-zero history predicts zeros forever; it must not lock
          if (hist_d == '0) begin
            state_d = ST_HUNT;
            fill_d  = '0;
            good_d  = '0;
          end else if (good_d == GOOD_DONE) begin
            state_d = ST_LOCKED;
            bad_d   = '0;
          end
        end
        ST_LOCKED: begin
          // flywheel: a channel error must not corrupt the local sequence
          hist_d  = {hist_q[WIDTH-2:0], pred};
          bit_inc = 1'b1;
          if (in_bit != pred) begin
            err_d   = 1'b1;
            err_inc = 1'b1;
            if (bad_q != BAD_DONE) bad_d = bad_q + BAD_W'(1);
          end else if (bad_q != '0) begin
            bad_d = bad_q - BAD_W'(1);
          end
          if (bad_d == BAD_DONE) begin
            state_d = ST_HUNT;
            fill_d  = '0;
          end
        end
        default: begin
          state_d = ST_HUNT;
          fill_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst_n) begin
      state_q <= ST_HUNT;
      hist_q  <= '0;
      fill_q  <= '0;
      good_q  <= '0;
      bad_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      err_q   <= err_d;
    end
  end

  assign locked  = (state_q == ST_LOCKED);
  assign err     = err_q;
  assign state_o = state_q;

  m_seq_sat_counter #(.W(CNT_W)) u_err_cnt (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clr       (clr_cnt),
    .inc       (err_inc),
    .count     (err_count)
  );

`ifdef MSEQ_CHK_STATS_EN
  m_seq_sat_counter #(.W(CNT_W)) u_bit_cnt (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clr       (clr_cnt),
    .inc       (bit_inc),
    .count     (bit_count)
  );
`else
  logic unused_bit_inc;
  assign unused_bit_inc = bit_inc;
`endif

endmodule

// File: tb/tb_m_sequence_checker.sv
// Scenario bench for m_sequence_checker: default instance plus a narrow-counter,
// high-unlock-threshold instance for saturation.
module tb_m_sequence_checker;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        in_bit;
  logic        in_valid;
  logic        clr_cnt;

  logic        locked_a, err_a;
  logic [15:0] cnt_a;
  logic [1:0]  state_a;
  logic        locked_b, err_b;
  logic [3:0]  cnt_b;
  logic [1:0]  state_b;
`ifdef MSEQ_CHK_STATS_EN
  logic [15:0] bitcnt_a;
  logic [3:0]  bitcnt_b;
`endif

  m_sequence_checker dut_a (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .clr_cnt   (clr_cnt),
    .locked    (locked_a),
    .err       (err_a),
    .err_count (cnt_a),
    .state_o   (state_a)
`ifdef MSEQ_CHK_STATS_EN
    ,
    .bit_count (bitcnt_a)
`endif
  );

  m_sequence_checker #(.CNT_W(4), .UNLOCK_ERRS(31)) dut_b (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .clr_cnt   (clr_cnt),
    .locked    (locked_b),
    .err       (err_b),
    .err_count (cnt_b),
    .state_o   (state_b)
`ifdef MSEQ_CHK_STATS_EN
    ,
    .bit_count (bitcnt_b)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [19:0] sb[$];
  logic [19:0] exp_v, obs;
  logic [0:14] pat;
  int          p;

  function automatic logic [19:0] mk(input logic l, input logic e, input logic [1:0] s,
                                     input logic [15:0] c);
    return {l, e, s, c};
  endfunction

  // state after the n-th valid bit of a clean stream from HUNT with empty fill
  function automatic logic [1:0] st_of(input int n);
    if (n < 4)  return 2'd0;
    if (n < 12) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic next_bit();
    logic b;
    b = pat[p];
    p = (p + 1) % 15;
    return b;
  endfunction

  task automatic cycle(input logic b, input logic v, input logic c);
    in_bit = b; in_valid = v; clr_cnt = c;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
    sys_rst_n = 1'b0;
    p = 0;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b1;
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    n_cmp++;
    if ({locked_a, err_a, state_a, cnt_a} !== 20'h0) begin
      n_bad++;
      $display("FAIL reset_a: got %h want 00000", {locked_a, err_a, state_a, cnt_a});
    end
    n_cmp++;
    if ({locked_b, err_b, state_b, cnt_b} !== 8'h0) begin
      n_bad++;
      $display("FAIL reset_b: got %h want 00", {locked_b, err_b, state_b, cnt_b});
    end
    sys_rst_n = 1'b0;
    p = 0;
  endtask

  task automatic test_clean_lock();
    do_reset();
    for (int i = 1; i <= 1500; i++) begin
      sb.push_back(mk(i >= 12, 1'b0, st_of(i), 16'd0));
      cycle(next_bit(), 1'b1, 1'b0);
      exp_v = sb.pop_front();
      obs = {locked_a, err_a, state_a, cnt_a};
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL clean_lock bit %0d: got %h want %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_single_error();
    for (int k = 1; k <= 20; k++) begin
      sb.push_back(mk(1'b1, k == 5, 2'd2, (k >= 5) ? 16'd1 : 16'd0));
      cycle(next_bit() ^ (k == 5), 1'b1, 1'b0);
      exp_v = sb.pop_front();
      obs = {locked_a, err_a, state_a, cnt_a};
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL single_err bit %0d: got %h want %h", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_burst_unlock();
    sb.push_back(mk(1'b1, 1'b0, 2'd2, 16'd0));
    for (int k = 1; k <= 4; k++)
      sb.push_back(mk(k < 4, 1'b1, (k < 4) ? 2'd2 : 2'd0, 16'(k)));
    for (int j = 1; j <= 16; j++)
      sb.push_back(mk(j >= 12, 1'b0, st_of(j), 16'd4));
    for (int k = 0; k < 21; k++) begin
      if (k == 0)     cycle(next_bit(), 1'b1, 1'b1);
      else if (k < 5) cycle(~next_bit(), 1'b1, 1'b0);
      else            cycle(next_bit(), 1'b1, 1'b0);
      exp_v = sb.pop_front();
      obs = {locked_a, err_a, state_a, cnt_a};
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL burst_unlock step %0d: got %h want %h", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_zero_input();
    do_reset();
    for (int i = 1; i <= 60; i++) begin
      sb.push_back(mk(1'b0, 1'b0, ((i % 5) == 4) ? 2'd1 : 2'd0, 16'd0));
      cycle(1'b0, 1'b1, 1'b0);
      exp_v = sb.pop_front();
      obs = {locked_a, err_a, state_a, cnt_a};
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL zero_input bit %0d: got %h want %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_valid_toggle();
    int nv;
    logic v, flip, clr;
    logic [15:0] ec;
    nv = 0;
    ec = 16'd0;
    do_reset();
    for (int c = 0; c < 60; c++) begin
      v    = ((c % 2) == 0);
      flip = v && (c == 44 || c == 52);
      clr  = v && (c == 52);
      if (v) nv++;
      if (flip) ec = clr ? 16'd0 : ec + 16'd1;
      else if (clr) ec = 16'd0;
      sb.push_back(mk(nv >= 12, flip, st_of(nv), ec));
      if (v) cycle(next_bit() ^ flip, 1'b1, clr);
      else   cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      exp_v = sb.pop_front();
      obs = {locked_a, err_a, state_a, cnt_a};
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL valid_toggle clk %0d: got %h want %h", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 1; i <= 12; i++) sb.push_back(mk(i >= 12, 1'b0, st_of(i), 16'd0));
    for (int k = 1; k <= 20; k++) sb.push_back(mk(1'b1, 1'b1, 2'd2, (k < 15) ? 16'(k) : 16'd15));
    for (int j = 1; j <= 6; j++)  sb.push_back(mk(1'b1, 1'b0, 2'd2, 16'd15));
    for (int s = 0; s < 38; s++) begin
      if (s >= 12 && s < 32) cycle(~next_bit(), 1'b1, 1'b0);
      else                   cycle(next_bit(), 1'b1, 1'b0);
      exp_v = sb.pop_front();
      obs = {locked_b, err_b, state_b, 12'h0, cnt_b};
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL saturation step %0d: got %h want %h", s, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_verify();
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      sb.push_back(mk(1'b0, 1'b0, st_of(i), 16'd0));
      cycle(next_bit(), 1'b1, 1'b0);
      exp_v = sb.pop_front();
      obs = {locked_b, err_b, state_b, 12'h0, cnt_b};
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL pre_reset bit %0d: got %h want %h", i, obs, exp_v);
      end
    end
    for (int r = 0; r < 2; r++) begin
      sys_rst_n = 1'b1;
      cycle(1'b1, (r == 0), 1'b0);
      n_cmp++;
      if ({locked_a, err_a, state_a, cnt_a, locked_b, err_b, state_b, cnt_b} !== 28'h0) begin
        n_bad++;
        $display("FAIL mid_reset pass %0d: got a=%h b=%h want 0", r,
                 {locked_a, err_a, state_a, cnt_a}, {locked_b, err_b, state_b, cnt_b});
      end
    end
    sys_rst_n = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pat = 15'b011001000111101;
    p = 0;
    sys_rst_n = 1'b1;
    in_bit = 1'b0; in_valid = 1'b0; clr_cnt = 1'b0;
    test_reset();
    test_clean_lock();
    test_single_error();
    test_burst_unlock();
    test_zero_input();
    test_valid_toggle();
    test_saturation();
    test_reset_mid_verify();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
